timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture_pkg.sv | 17 +
 rtl/timestamp_capture_sync_fifo.sv | 56 +++++
 rtl/timestamp_capture.sv | 80 ++++++++
 tb/tb_timestamp_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_capture_pkg.sv
// Shared widths and defaults for the timestamp capture path.
package timestamp_capture_pkg;

    // Timestamp width, matching the upstream 16-bit free-running counter
    localparam int TS_CW    = 16;
    // Default number of buffered timestamps
    localparam int TS_DEPTH = 4;
    // Dropped-event counter width and its saturation value
    localparam int DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Occupancy width able to represent 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/timestamp_capture_sync_fifo.sv
// Show-ahead synchronous FIFO; power-of-two depth so pointers wrap for free.
// A push into a full FIFO is taken when a pop happens on the same edge.
import timestamp_capture_pkg::*;

module sync_fifo #(
    parameter int DEPTH = TS_DEPTH,
    parameter int W     = TS_CW,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr];

    // Storage is left unreset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps level
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/timestamp_capture.sv
// Timestamps rising edges of an asynchronous event line with the local
// free-running count and buffers them for a downstream consumer.
import timestamp_capture_pkg::*;

module timestamp_capture #(
    parameter int DEPTH = TS_DEPTH,
    parameter int CW    = TS_CW,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     count,
    input  logic              event_in,
    output logic [CW-1:0]     ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clear_ovf
);

    logic s1, s2, s3;
    logic rise;
    logic pop;
    logic full;
    logic empty;
    logic drop;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= event_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A held-high event produces a single one-cycle rise
    assign rise     = s2 & ~s3;
    assign ts_valid = ~empty;
    assign pop      = ts_valid & ts_ready;
    // Full with a same-edge pop still has room, so only that case drops
    assign drop     = rise & full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rise),
        .wdata (count),
        .pop   (pop),
        .rdata (ts_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Sticky overflow and saturating drop count; a drop beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf)                drop_cnt <= DROP_W'(1);
            else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_W'(1);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench with a scoreboard queue; a negedge monitor checks pops.
module tb_timestamp_capture;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk;
    logic          reset;
    logic [CW-1:0] count;
    logic          event_in;
    logic [CW-1:0] ts_data;
    logic          ts_valid;
    logic          ts_ready;
    logic [2:0]    level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clear_ovf;
    logic          load;
    logic [CW-1:0] load_val;

    int            checks = 0;
    int            errors = 0;
    int            vcycles = 0;
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] exp_v;

    timestamp_capture #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .event_in  (event_in),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream free-running counter model, loadable to reach wrap quickly
    always @(posedge clk) begin
        if (reset)     count <= '0;
        else if (load) count <= load_val;
        else           count <= count + 16'd1;
    end

    // Monitor: every accepted head must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && ts_valid) vcycles++;
        if (!reset && ts_valid && ts_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", ts_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (ts_data !== exp_v) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", ts_data, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_count(input logic [CW-1:0] v);
        int n = 0;
        while (count !== v && n < 3000) begin
            tick(1);
            n++;
        end
        if (count !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_count: got %0d expected %0d", count, v);
        end
    endtask

    // Raise event_in so it is first sampled on the edge where count == at
    task automatic pulse(input logic [CW-1:0] at, input int hi, input int lo);
        wait_count(at);
        event_in = 1'b1;
        tick(hi);
        event_in = 1'b0;
        tick(lo);
    endtask

    task automatic load_count(input logic [CW-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick(1);
        load     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; event_in = 1'b0; ts_ready = 1'b0;
        clear_ovf = 1'b0; load = 1'b0; load_val = '0;
        tick(3);
        chk("rst_level", level, 0);
        chk("rst_valid", ts_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;

        // Single capture, consumer always ready
        ts_ready = 1'b1;
        vcycles  = 0;
        exp_q.push_back(16'd102);
        pulse(16'd100, 3, 3);
        tick(4);
        chk("single_valid_cycles", vcycles, 1);
        chk("single_q_empty", exp_q.size(), 0);
        chk("single_level", level, 0);

        // Five pulses into a stalled FIFO: four stored, one dropped
        ts_ready = 1'b0;
        exp_q.push_back(16'd202);
        exp_q.push_back(16'd208);
        exp_q.push_back(16'd214);
        exp_q.push_back(16'd220);
        pulse(16'd200, 3, 3);
        pulse(16'd206, 3, 3);
        pulse(16'd212, 3, 3);
        pulse(16'd218, 3, 3);
        pulse(16'd224, 3, 3);
        tick(3);
        chk("ovf5_level", level, 4);
        chk("ovf5_overflow", overflow, 1);
        chk("ovf5_drop_cnt", drop_cnt, 1);
        ts_ready = 1'b1;
        tick(6);
        chk("ovf5_drain_level", level, 0);
        chk("ovf5_drain_q", exp_q.size(), 0);
        ts_ready  = 1'b0;
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("clear_overflow", overflow, 0);
        chk("clear_drop_cnt", drop_cnt, 0);

        // Full FIFO with push and pop on the same edge
        exp_q.push_back(16'd302);
        exp_q.push_back(16'd308);
        exp_q.push_back(16'd314);
        exp_q.push_back(16'd320);
        pulse(16'd300, 3, 3);
        pulse(16'd306, 3, 3);
        pulse(16'd312, 3, 3);
        pulse(16'd318, 3, 3);
        chk("full_level", level, 4);
        wait_count(16'd330);
        event_in = 1'b1;
        tick(2);
        ts_ready = 1'b1;
        exp_q.push_back(16'd332);
        tick(1);
        ts_ready = 1'b0;
        event_in = 1'b0;
        chk("pushpop_level", level, 4);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_drop_cnt", drop_cnt, 0);
        ts_ready = 1'b1;
        tick(8);
        chk("pushpop_drain_level", level, 0);
        chk("pushpop_drain_q", exp_q.size(), 0);

        // Counter wrap: sampled at 0xFFFE, captured value is 0x0000
        load_count(16'hFFF0);
        exp_q.push_back(16'h0000);
        wait_count(16'hFFFE);
        event_in = 1'b1;
        tick(3);
        event_in = 1'b0;
        tick(5);
        chk("wrap_q", exp_q.size(), 0);
        chk("wrap_level", level, 0);

        // 300 drops saturate the counter; clear racing a drop
        ts_ready = 1'b0;
        load_count(16'd1000);
        exp_q.push_back(16'd1002);
        exp_q.push_back(16'd1004);
        exp_q.push_back(16'd1006);
        exp_q.push_back(16'd1008);
        for (int i = 0; i < 304; i++) begin
            event_in = 1'b1;
            tick(1);
            event_in = 1'b0;
            tick(1);
        end
        tick(3);
        chk("sat_drop_cnt", drop_cnt, 255);
        chk("sat_overflow", overflow, 1);
        chk("sat_level", level, 4);
        wait_count(16'd1620);
        event_in = 1'b1;
        tick(2);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        event_in  = 1'b0;
        chk("race_overflow", overflow, 1);
        chk("race_drop_cnt", drop_cnt, 1);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("clear2_overflow", overflow, 0);
        chk("clear2_drop_cnt", drop_cnt, 0);
        ts_ready = 1'b1;
        tick(6);
        chk("sat_drain_q", exp_q.size(), 0);
        ts_ready = 1'b0;

        // Reset with entries stored and event_in held high
        exp_q.push_back(16'd1702);
        exp_q.push_back(16'd1708);
        exp_q.push_back(16'd1714);
        pulse(16'd1700, 3, 3);
        pulse(16'd1706, 3, 3);
        pulse(16'd1712, 3, 3);
        chk("pre_rst_level", level, 3);
        event_in = 1'b1;
        tick(1);
        reset = 1'b1;
        exp_q.delete();
        tick(2);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", ts_valid, 0);
        reset    = 1'b0;
        vcycles  = 0;
        ts_ready = 1'b1;
        exp_q.push_back(16'd2);
        tick(8);
        chk("post_rst_valid_cycles", vcycles, 1);
        chk("post_rst_q", exp_q.size(), 0);
        chk("post_rst_level", level, 0);
        event_in = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
